// File: rtl/match_controller.sv
// Round/health manager for N fighters: applies damage, runs the round clock,
// tracks round wins and drives registered BCD digits for the HEX displays.
module match_controller #(
  parameter int NUM_PLAYERS    = 2,
  parameter int HP_MAX         = 99,
  parameter int DMG_W          = 4,
  parameter int TRADE_MODE     = 0,
  parameter int ROUND_SECS     = 99,
  parameter int FRAMES_PER_SEC = 60,
  parameter int ROUNDS_TO_WIN  = 2,
  parameter int HOLD_FRAMES    = 120,
  localparam int HP_W          = $clog2(HP_MAX + 1)
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         frame_tick,
  input  logic                         start,
  input  logic [NUM_PLAYERS-1:0]       hit_valid,
  input  logic [NUM_PLAYERS*DMG_W-1:0] hit_dmg,
  output logic [NUM_PLAYERS*HP_W-1:0]  health,
  output logic [NUM_PLAYERS*4-1:0]     hp_tens,
  output logic [NUM_PLAYERS*4-1:0]     hp_ones,
  output logic [3:0]                   time_tens,
  output logic [3:0]                   time_ones,
  output logic [NUM_PLAYERS*2-1:0]     wins,
  output logic [2:0]                   state,
  output logic                         round_active,
  output logic                         ko_pulse,
  output logic [2:0]                   winner
);

  localparam int TM_W = $clog2(ROUND_SECS + 1);
  localparam int FR_W = $clog2(FRAMES_PER_SEC + 1);
  localparam int HD_W = $clog2(HOLD_FRAMES + 1);
  localparam int SW   = (HP_W > DMG_W) ? HP_W : DMG_W;
  localparam logic [2:0] NO_WIN     = 3'd7;
  localparam logic [1:0] WIN_TARGET = 2'(ROUNDS_TO_WIN);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FIGHT     = 3'd1,
    ROUND_END = 3'd2,
    GAME_OVER = 3'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [HP_W-1:0]   health_reg [NUM_PLAYERS];
  logic [HP_W-1:0]   hit_health [NUM_PLAYERS];
  logic [1:0]        wins_reg   [NUM_PLAYERS];
  logic [TM_W-1:0]   timer_reg;
  logic [FR_W-1:0]   frame_cnt_reg;
  logic [HD_W-1:0]   hold_cnt_reg;
  logic [2:0]        winner_reg;
  logic              ko_pulse_reg;
  logic [3:0]        time_tens_reg, time_ones_reg;
  logic [6:0]        timer7;

  int                hit_cnt, alive_cnt, max_cnt;
  logic              trade_block, round_over, match_won, hold_done, sec_wrap;
  logic [2:0]        survivor, max_idx, round_winner, match_idx;
  logic [HP_W-1:0]   max_hp;

  // Per-player damage application, output packing and health BCD
  for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
    logic [SW-1:0] hp_ext, dmg_ext;
    logic [6:0]    hp7;
    logic [3:0]    tens_reg, ones_reg;

    assign hp_ext  = SW'(health_reg[gi]);
    assign dmg_ext = SW'(hit_dmg[gi*DMG_W +: DMG_W]);
    assign hit_health[gi] = (!hit_valid[gi] || trade_block) ? health_reg[gi] :
                            (dmg_ext >= hp_ext) ? '0 : HP_W'(hp_ext - dmg_ext);

    assign hp7 = 7'(health_reg[gi]);
    always_ff @(posedge Clk) begin
      tens_reg <= 4'(hp7 / 7'd10);
      ones_reg <= 4'(hp7 % 7'd10);
    end

    assign health[gi*HP_W +: HP_W] = health_reg[gi];
    assign hp_tens[gi*4 +: 4]      = tens_reg;
    assign hp_ones[gi*4 +: 4]      = ones_reg;
    assign wins[gi*2 +: 2]         = wins_reg[gi];
  end

  always_comb begin
    hit_cnt = 0;
    for (int i = 0; i < NUM_PLAYERS; i++)
      if (hit_valid[i]) hit_cnt++;
    trade_block = (TRADE_MODE == 0) && (hit_cnt > 1);
  end

  // Round-end evaluation on the registered (already updated) health and timer
  always_comb begin
    alive_cnt = 0;
    survivor  = NO_WIN;
    max_hp    = '0;
    max_cnt   = 0;
    max_idx   = NO_WIN;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (health_reg[i] != '0) begin
        alive_cnt++;
        survivor = 3'(i);
      end
      if (health_reg[i] > max_hp) begin
        max_hp  = health_reg[i];
        max_cnt = 1;
        max_idx = 3'(i);
      end else if (health_reg[i] == max_hp) begin
        max_cnt++;
      end
    end
    round_over = (alive_cnt <= 1) || (timer_reg == '0);
    if (alive_cnt <= 1)
      round_winner = (alive_cnt == 1) ? survivor : NO_WIN;
    else
      round_winner = (max_cnt == 1) ? max_idx : NO_WIN;
  end

  always_comb begin
    match_won = 1'b0;
    match_idx = NO_WIN;
    for (int i = 0; i < NUM_PLAYERS; i++)
      if (wins_reg[i] == WIN_TARGET) begin
        match_won = 1'b1;
        match_idx = 3'(i);
      end
  end

  assign hold_done = (hold_cnt_reg == HD_W'(HOLD_FRAMES));
  assign sec_wrap  = (frame_cnt_reg == FR_W'(FRAMES_PER_SEC - 1));

  always_ff @(posedge Clk) begin
    if (!Reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (start) state_next = FIGHT;
      FIGHT:     if (round_over) state_next = ROUND_END;
      ROUND_END: if (hold_done) state_next = match_won ? GAME_OVER : FIGHT;
      GAME_OVER: if (start) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Datapath; a tick landing on a transition edge is dropped since the new state starts its counters at 0
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        health_reg[i] <= HP_W'(HP_MAX);
        wins_reg[i]   <= 2'd0;
      end
      timer_reg     <= TM_W'(ROUND_SECS);
      frame_cnt_reg <= '0;
      hold_cnt_reg  <= '0;
      winner_reg    <= NO_WIN;
      ko_pulse_reg  <= 1'b0;
    end else begin
      ko_pulse_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            frame_cnt_reg <= '0;
            hold_cnt_reg  <= '0;
          end
        end
        FIGHT: begin
          if (round_over) begin
            ko_pulse_reg <= 1'b1;
            winner_reg   <= round_winner;
            hold_cnt_reg <= '0;
            for (int i = 0; i < NUM_PLAYERS; i++)
              if (round_winner == 3'(i) && wins_reg[i] != 2'd3)
                wins_reg[i] <= wins_reg[i] + 2'd1;
          end else begin
            for (int i = 0; i < NUM_PLAYERS; i++)
              health_reg[i] <= hit_health[i];
            if (frame_tick) begin
              if (sec_wrap) begin
                frame_cnt_reg <= '0;
                if (timer_reg != '0) timer_reg <= timer_reg - TM_W'(1);
              end else begin
                frame_cnt_reg <= frame_cnt_reg + FR_W'(1);
              end
            end
          end
        end
        ROUND_END: begin
          if (hold_done) begin
            hold_cnt_reg <= '0;
            if (match_won) begin
              winner_reg <= match_idx;
            end else begin
              for (int i = 0; i < NUM_PLAYERS; i++)
                health_reg[i] <= HP_W'(HP_MAX);
              timer_reg     <= TM_W'(ROUND_SECS);
              frame_cnt_reg <= '0;
              winner_reg    <= NO_WIN;
            end
          end else if (frame_tick) begin
            hold_cnt_reg <= hold_cnt_reg + HD_W'(1);
          end
        end
        GAME_OVER: begin
          if (start) begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
              health_reg[i] <= HP_W'(HP_MAX);
              wins_reg[i]   <= 2'd0;
            end
            timer_reg     <= TM_W'(ROUND_SECS);
            frame_cnt_reg <= '0;
            hold_cnt_reg  <= '0;
            winner_reg    <= NO_WIN;
          end
        end
        default: ;
      endcase
    end
  end

  assign timer7 = 7'(timer_reg);
  always_ff @(posedge Clk) begin
    time_tens_reg <= 4'(timer7 / 7'd10);
    time_ones_reg <= 4'(timer7 % 7'd10);
  end

  assign time_tens    = time_tens_reg;
  assign time_ones    = time_ones_reg;
  assign state        = state_reg;
  assign round_active = (state_reg == FIGHT);
  assign ko_pulse     = ko_pulse_reg;
  assign winner       = winner_reg;

endmodule
